seg7_scan_driver: RTL and testbench

- Parametrised, time-multiplexed driver for an N-digit common-cathode or common-anode 7-segment display.
- Holds a double-buffered digit value and scans one digit per prescaler period.
- Decodes BCD or hex, with optional leading-zero blanking and per-digit decimal points.
- Sits between the counter core and the output pads, replacing a per-digit combinational decoder.

---
 rtl/seg7_scan_driver.sv | 170 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Time-multiplexed driver for an N-digit 7-segment display.
//             Double-buffered digit values (pending -> shadow at frame
//             boundaries), BCD/hex decode, leading-zero blanking, per-digit
//             decimal points and selectable common-anode polarity.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             en                - scan enable (0 blanks and freezes scanning)
//             load              - strobe capturing digits_in / dp_in
//             digits_in, dp_in  - nibble k / bit k belong to digit k
//             hex_mode          - 1: A..F glyphs, 0: 10..15 shown as F
//             blank_lz          - 1: blank leading zeros
//             segment_out       - {g,f,e,d,c,b,a}, registered
//             dp_out, digit_sel - decimal point / one-hot digit, registered
//             frame_done        - one-cycle pulse when the scan wraps
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    output logic [6:0]              segment_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_ps_w  = $clog2(PRESCALE);

    localparam logic [c_ps_w-1:0]     c_ps_last  = c_ps_w'(PRESCALE - 1);
    localparam logic [c_idx_w-1:0]    c_idx_last = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [6:0]            c_seg_off  = {7{COMMON_ANODE}};
    localparam logic [NUM_DIGITS-1:0] c_sel_off  = {NUM_DIGITS{COMMON_ANODE}};
    localparam logic                  c_dp_off   = COMMON_ANODE;
    localparam logic [6:0]            c_seg_err  = 7'b1110001;

    logic [c_ps_w-1:0]       r_prescale;
    logic [c_idx_w-1:0]      r_index;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic [NUM_DIGITS-1:0]   r_pending_dp;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [6:0]              r_segment;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_digit_sel;
    logic                    r_frame_done;

    logic                    w_step;
    logic                    w_wrap;
    logic [3:0]              w_nibble;
    logic                    w_dp;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic                    w_zero;
    logic                    w_blank;
    logic [6:0]              w_dec;
    logic [6:0]              w_seg;

    assign w_step = en && (r_prescale == c_ps_last);
    assign w_wrap = w_step && (r_index == c_idx_last);

    // Select the active digit and decide blanking. Walking from the most
    // significant digit down, w_zero stays set while every nibble from the
    // top down to k is zero, which is exactly the leading-zero condition.
    always_comb begin
        w_nibble = 4'h0;
        w_dp     = 1'b0;
        w_sel    = '0;
        w_zero   = 1'b1;
        w_blank  = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero = w_zero && (r_shadow[4*k +: 4] == 4'h0);
            if (r_index == c_idx_w'(k)) begin
                w_nibble = r_shadow[4*k +: 4];
                w_dp     = r_shadow_dp[k];
                w_sel[k] = 1'b1;
                w_blank  = blank_lz && w_zero && (k != 0);
            end
        end
    end

    // Glyph order {g,f,e,d,c,b,a}; F doubles as the non-hex error glyph.
    always_comb begin
        w_dec = c_seg_err;
        case (w_nibble)
            4'h0: w_dec = 7'b0111111;
            4'h1: w_dec = 7'b0000110;
            4'h2: w_dec = 7'b1011011;
            4'h3: w_dec = 7'b1001111;
            4'h4: w_dec = 7'b1100110;
            4'h5: w_dec = 7'b1101101;
            4'h6: w_dec = 7'b1111101;
            4'h7: w_dec = 7'b0000111;
            4'h8: w_dec = 7'b1111111;
            4'h9: w_dec = 7'b1101111;
            4'hA: w_dec = hex_mode ? 7'b1110111 : c_seg_err;
            4'hB: w_dec = hex_mode ? 7'b1111100 : c_seg_err;
            4'hC: w_dec = hex_mode ? 7'b0111001 : c_seg_err;
            4'hD: w_dec = hex_mode ? 7'b1011110 : c_seg_err;
            4'hE: w_dec = hex_mode ? 7'b1111001 : c_seg_err;
            default: w_dec = c_seg_err;
        endcase
        w_seg = w_blank ? 7'b0000000 : w_dec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale   <= '0;
            r_index      <= '0;
            r_pending    <= '0;
            r_pending_dp <= '0;
            r_shadow     <= '0;
            r_shadow_dp  <= '0;
            r_frame_done <= 1'b0;
            r_segment    <= c_seg_off;
            r_dp         <= c_dp_off;
            r_digit_sel  <= c_sel_off;
        end else begin
            if (load) begin
                r_pending    <= digits_in;
                r_pending_dp <= dp_in;
            end

            // Shadow only moves between frames while scanning; a load on
            // that same edge bypasses pending so it is not a frame late.
            if (!en || w_wrap) begin
                r_shadow    <= load ? digits_in : r_pending;
                r_shadow_dp <= load ? dp_in     : r_pending_dp;
            end

            if (w_step) begin
                r_prescale <= '0;
                r_index    <= w_wrap ? '0 : r_index + c_idx_w'(1);
            end else if (en) begin
                r_prescale <= r_prescale + c_ps_w'(1);
            end

            r_frame_done <= w_wrap;

            // Outputs sample the pre-edge index, so segment data and
            // digit_sel always change on the same edge.
            if (en) begin
                r_segment   <= w_seg ^ c_seg_off;
                r_dp        <= w_dp ^ c_dp_off;
                r_digit_sel <= w_sel ^ c_sel_off;
            end else begin
                r_segment   <= c_seg_off;
                r_dp        <= c_dp_off;
                r_digit_sel <= c_sel_off;
            end
        end
    end

    assign segment_out = r_segment;
    assign dp_out      = r_dp;
    assign digit_sel   = r_digit_sel;
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Purpose  : Directed self-checking bench for seg7_scan_driver. Two DUTs
//             (common cathode and common anode) share every input so each
//             scenario is checked in both polarities.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam logic [6:0] c_g0 = 7'b0111111;
    localparam logic [6:0] c_g1 = 7'b0000110;
    localparam logic [6:0] c_g2 = 7'b1011011;
    localparam logic [6:0] c_g3 = 7'b1001111;
    localparam logic [6:0] c_g4 = 7'b1100110;
    localparam logic [6:0] c_g5 = 7'b1101101;
    localparam logic [6:0] c_g6 = 7'b1111101;
    localparam logic [6:0] c_g7 = 7'b0000111;
    localparam logic [6:0] c_g8 = 7'b1111111;
    localparam logic [6:0] c_ga = 7'b1110111;
    localparam logic [6:0] c_gf = 7'b1110001;
    localparam logic [6:0] c_gx = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        hex_mode;
    logic        blank_lz;

    logic [6:0]  seg_cc, seg_ca;
    logic        dp_cc, dp_ca;
    logic [3:0]  sel_cc, sel_ca;
    logic        fd_cc, fd_ca;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_scan_driver #(.NUM_DIGITS(4), .PRESCALE(4), .COMMON_ANODE(1'b0)) u_dut_cc (
        .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .hex_mode(hex_mode), .blank_lz(blank_lz),
        .segment_out(seg_cc), .dp_out(dp_cc), .digit_sel(sel_cc), .frame_done(fd_cc)
    );

    seg7_scan_driver #(.NUM_DIGITS(4), .PRESCALE(4), .COMMON_ANODE(1'b1)) u_dut_ca (
        .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .hex_mode(hex_mode), .blank_lz(blank_lz),
        .segment_out(seg_ca), .dp_out(dp_ca), .digit_sel(sel_ca), .frame_done(fd_ca)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Packed view {frame_done, dp, digit_sel, segments}; frame_done is not a pad.
    function automatic logic [12:0] pk(input bit ca, input logic fd, input logic dp,
                                       input logic [3:0] sel, input logic [6:0] seg);
        return ca ? {fd, ~dp, ~sel, ~seg} : {fd, dp, sel, seg};
    endfunction

    task automatic check_both(input string tag, input logic fd, input logic dp,
                              input logic [3:0] sel, input logic [6:0] seg);
        check({tag, "/cc"}, {19'b0, fd_cc, dp_cc, sel_cc, seg_cc}, {19'b0, pk(1'b0, fd, dp, sel, seg)});
        check({tag, "/ca"}, {19'b0, fd_ca, dp_ca, sel_ca, seg_ca}, {19'b0, pk(1'b1, fd, dp, sel, seg)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 16-cycle frame starting on the edge that first shows digit 0.
    // load_at >= 0 raises load for the edge following step load_at.
    task automatic run_frame(input string tag,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] dps, input int load_at,
                             input logic [15:0] lval, input logic [3:0] ldp);
        logic [6:0] seg;
        int d;
        for (int i = 0; i < 16; i++) begin
            step();
            d = i / 4;
            case (d)
                0:       seg = s0;
                1:       seg = s1;
                2:       seg = s2;
                default: seg = s3;
            endcase
            check_both(tag, (i == 15), dps[d], 4'b0001 << d, seg);
            if (i == load_at) begin
                load      = 1'b1;
                digits_in = lval;
                dp_in     = ldp;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    task automatic restart(input logic [15:0] v, input logic [3:0] dps);
        rst  = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        step();
        rst       = 1'b0;
        load      = 1'b1;
        digits_in = v;
        dp_in     = dps;
        step();
        load = 1'b0;
        en   = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        hex_mode  = 1'b1;
        blank_lz  = 1'b0;
        step();
        step();
        check_both("reset", 1'b0, 1'b0, 4'b0000, c_gx);

        rst       = 1'b0;
        load      = 1'b1;
        digits_in = 16'h1234;
        dp_in     = 4'b0100;
        step();
        load = 1'b0;
        check_both("en0_load", 1'b0, 1'b0, 4'b0000, c_gx);

        en = 1'b1;
        run_frame("f1_1234", c_g4, c_g3, c_g2, c_g1, 4'b0100, -1, 16'h0, 4'h0);
        // Load 5678 while index 1 is being scanned: must not tear this frame.
        run_frame("f2_1234", c_g4, c_g3, c_g2, c_g1, 4'b0100, 5, 16'h5678, 4'b0000);
        // Load 4321 on the exact wrap edge: must appear in the next frame.
        run_frame("f3_5678", c_g8, c_g7, c_g6, c_g5, 4'b0000, 14, 16'h4321, 4'b0001);
        run_frame("f4_4321", c_g1, c_g2, c_g3, c_g4, 4'b0001, -1, 16'h0, 4'h0);

        step();
        check_both("pre_en0_a", 1'b0, 1'b1, 4'b0001, c_g1);
        step();
        check_both("pre_en0_b", 1'b0, 1'b1, 4'b0001, c_g1);
        en = 1'b0;
        step();
        check_both("en0_a", 1'b0, 1'b0, 4'b0000, c_gx);
        step();
        check_both("en0_b", 1'b0, 1'b0, 4'b0000, c_gx);
        en = 1'b1;
        step();
        check_both("resume_a", 1'b0, 1'b1, 4'b0001, c_g1);
        step();
        check_both("resume_b", 1'b0, 1'b1, 4'b0001, c_g1);
        step();
        check_both("resume_next", 1'b0, 1'b0, 4'b0010, c_g2);

        rst       = 1'b1;
        load      = 1'b1;
        digits_in = 16'hFFFF;
        dp_in     = 4'b1111;
        step();
        load = 1'b0;
        check_both("rst_mid", 1'b0, 1'b0, 4'b0000, c_gx);
        rst = 1'b0;
        step();
        check_both("post_rst", 1'b0, 1'b0, 4'b0001, c_g0);

        blank_lz = 1'b1;
        restart(16'h0070, 4'b0000);
        run_frame("lz_0070", c_g0, c_g7, c_gx, c_gx, 4'b0000, -1, 16'h0, 4'h0);
        restart(16'h0000, 4'b1000);
        run_frame("lz_0000", c_g0, c_gx, c_gx, c_gx, 4'b1000, -1, 16'h0, 4'h0);

        blank_lz = 1'b0;
        hex_mode = 1'b1;
        restart(16'h00AF, 4'b0000);
        run_frame("hex1_00AF", c_gf, c_ga, c_g0, c_g0, 4'b0000, -1, 16'h0, 4'h0);
        hex_mode = 1'b0;
        restart(16'h00AF, 4'b0000);
        run_frame("hex0_00AF", c_gf, c_gf, c_g0, c_g0, 4'b0000, -1, 16'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
